// File: rtl/audio_cortex_pkg.sv
// Shared helpers for audio_cortex boundary blocks: width math and parameter checks.
package audio_cortex_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Filter counter width; a 1-deep filter still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned filter_len);
    return (filter_len > 1) ? clog2(filter_len) : 1;
  endfunction

  // Sync chains shorter than 2 do not resolve metastability; a 0-length filter is meaningless.
  function automatic bit params_legal(input int unsigned sync_stages,
                                      input int unsigned filter_len);
    return (sync_stages >= 2) && (filter_len >= 1);
  endfunction

endpackage

// File: rtl/dd_sync_filt_ch.sv
// Single channel: synchroniser chain, stability filter and rise/fall pulse registers.
module dd_sync_filt_ch
  import audio_cortex_pkg::*;
#(
  parameter int unsigned P_NO_SYNC_STAGES = 2,
  parameter int unsigned P_FILTER_LEN     = 4,
  parameter logic        P_RST_VAL        = 1'b0
) (
  input  logic clk_ir,
  input  logic rst_ih,
  input  logic signal_id,
  output logic signal_od,
  output logic rise_od,
  output logic fall_od,
  output logic edge_od   // next-cycle pulse, feeds the registered any_edge in the top
);

  localparam int unsigned    CntW   = cnt_width(P_FILTER_LEN);
  localparam logic [CntW-1:0] CntMax = CntW'(P_FILTER_LEN - 1);

  logic [P_NO_SYNC_STAGES-1:0] sync_f;
  logic                        s;
  logic                        stable_f, stable_d;
  logic [CntW-1:0]             cnt_f, cnt_d;
  logic                        rise_f, rise_d;
  logic                        fall_f, fall_d;

  assign s = sync_f[P_NO_SYNC_STAGES-1];

  // Synchroniser shift chain; index 0 samples the asynchronous input.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      sync_f <= {P_NO_SYNC_STAGES{P_RST_VAL}};
    end else begin
      sync_f <= {sync_f[P_NO_SYNC_STAGES-2:0], signal_id};
    end
  end

  // Filter next state: accept a disagreement only after it persists P_FILTER_LEN cycles.
  always_comb begin
    stable_d = stable_f;
    cnt_d    = cnt_f;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s == stable_f) begin
      cnt_d = '0;
    end else if (cnt_f == CntMax) begin
      stable_d = s;
      cnt_d    = '0;
      rise_d   = s;
      fall_d   = ~s;
    end else begin
      cnt_d = cnt_f + CntW'(1);
    end
  end

  // Filter state and pulse registers.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      stable_f <= P_RST_VAL;
      cnt_f    <= '0;
      rise_f   <= 1'b0;
      fall_f   <= 1'b0;
    end else begin
      stable_f <= stable_d;
      cnt_f    <= cnt_d;
      rise_f   <= rise_d;
      fall_f   <= fall_d;
    end
  end

  assign signal_od = stable_f;
  assign rise_od   = rise_f;
  assign fall_od   = fall_f;
  assign edge_od   = rise_d | fall_d;

endmodule

// File: rtl/dd_sync_filt.sv
// Multi-channel synchroniser with per-channel glitch filter and edge detection.
module dd_sync_filt
  import audio_cortex_pkg::*;
#(
  parameter int unsigned         P_WIDTH          = 4,
  parameter int unsigned         P_NO_SYNC_STAGES = 2,
  parameter int unsigned         P_FILTER_LEN     = 4,
  parameter logic [P_WIDTH-1:0]  P_RST_VAL        = '0
) (
  input  logic               clk_ir,
  input  logic               rst_ih,
  input  logic [P_WIDTH-1:0] signal_id,
  output logic [P_WIDTH-1:0] signal_od,
  output logic [P_WIDTH-1:0] rise_od,
  output logic [P_WIDTH-1:0] fall_od,
  output logic               any_edge_od
);

  if (!params_legal(P_NO_SYNC_STAGES, P_FILTER_LEN)) begin : gen_bad_params
    $error("dd_sync_filt: P_NO_SYNC_STAGES must be >= 2 and P_FILTER_LEN >= 1");
  end

  logic [P_WIDTH-1:0] edge_d;
  logic               any_edge_f;

  for (genvar c = 0; c < P_WIDTH; c++) begin : gen_ch
    dd_sync_filt_ch #(
      .P_NO_SYNC_STAGES (P_NO_SYNC_STAGES),
      .P_FILTER_LEN     (P_FILTER_LEN),
      .P_RST_VAL        (P_RST_VAL[c])
    ) u_ch (
      .clk_ir    (clk_ir),
      .rst_ih    (rst_ih),
      .signal_id (signal_id[c]),
      .signal_od (signal_od[c]),
      .rise_od   (rise_od[c]),
      .fall_od   (fall_od[c]),
      .edge_od   (edge_d[c])
    );
  end

  // Register the OR of next-cycle pulses so any_edge lines up with rise/fall.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      any_edge_f <= 1'b0;
    end else begin
      any_edge_f <= |edge_d;
    end
  end

  assign any_edge_od = any_edge_f;

endmodule

// File: tb/tb_dd_sync_filt.sv
// Directed bench for dd_sync_filt across default, non-zero reset and pass-through configs.
module tb_dd_sync_filt;

  logic clk_ir = 1'b0;
  always #5 clk_ir = ~clk_ir;

  int n_cmp = 0;
  int n_bad = 0;

  // Default configuration, reset value 0.
  logic       rst_a = 1'b1;
  logic [3:0] sig_a = 4'b0000;
  logic [3:0] so_a, ro_a, fo_a;
  logic       any_a;

  // Non-zero reset value.
  logic       rst_b = 1'b1;
  logic [3:0] sig_b = 4'b1010;
  logic [3:0] so_b, ro_b, fo_b;
  logic       any_b;

  // Filter length 1, 3-stage sync.
  logic       rst_c = 1'b1;
  logic [3:0] sig_c = 4'b0000;
  logic [3:0] so_c, ro_c, fo_c;
  logic       any_c;

  dd_sync_filt u_dut_a (
    .clk_ir      (clk_ir),
    .rst_ih      (rst_a),
    .signal_id   (sig_a),
    .signal_od   (so_a),
    .rise_od     (ro_a),
    .fall_od     (fo_a),
    .any_edge_od (any_a)
  );

  dd_sync_filt #(
    .P_RST_VAL (4'b0101)
  ) u_dut_b (
    .clk_ir      (clk_ir),
    .rst_ih      (rst_b),
    .signal_id   (sig_b),
    .signal_od   (so_b),
    .rise_od     (ro_b),
    .fall_od     (fo_b),
    .any_edge_od (any_b)
  );

  dd_sync_filt #(
    .P_NO_SYNC_STAGES (3),
    .P_FILTER_LEN     (1)
  ) u_dut_c (
    .clk_ir      (clk_ir),
    .rst_ih      (rst_c),
    .signal_id   (sig_c),
    .signal_od   (so_c),
    .rise_od     (ro_c),
    .fall_od     (fo_c),
    .any_edge_od (any_c)
  );

  typedef struct {
    logic       rst;
    logic [3:0] sig;
    logic [3:0] exp_sig;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    logic       exp_any;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] sig, input logic [3:0] es,
                     input logic [3:0] er, input logic [3:0] ef, input logic ea);
    vec_t v;
    v.rst = rst; v.sig = sig; v.exp_sig = es; v.exp_rise = er; v.exp_fall = ef; v.exp_any = ea;
    tbl.push_back(v);
  endtask

  // n cycles with no pulses expected.
  task automatic add_n(input int n, input logic rst, input logic [3:0] sig,
                       input logic [3:0] es);
    for (int i = 0; i < n; i++) add(rst, sig, es, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic [3:0] so, input logic [3:0] ro, input logic [3:0] fo,
                           input logic any, input logic [3:0] es, input logic [3:0] er,
                           input logic [3:0] ef, input logic ea);
    check({tag, ".signal"}, idx, so, es);
    check({tag, ".rise"}, idx, ro, er);
    check({tag, ".fall"}, idx, fo, ef);
    check({tag, ".any_edge"}, idx, {3'b000, any}, {3'b000, ea});
  endtask

  initial begin
    // Reset, then latency of a single rise and fall on ch0 (accept on edge 5).
    add_n(3, 1'b1, 4'b0000, 4'b0000);
    add_n(5, 1'b0, 4'b0001, 4'b0000);
    add(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    add_n(2, 1'b0, 4'b0001, 4'b0001);
    add_n(5, 1'b0, 4'b0000, 4'b0001);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    add_n(2, 1'b0, 4'b0000, 4'b0000);
    // Glitch on ch1: 3 high, 1 low, 3 high never reaches the 4-sample threshold.
    add_n(3, 1'b0, 4'b0010, 4'b0000);
    add_n(1, 1'b0, 4'b0000, 4'b0000);
    add_n(3, 1'b0, 4'b0010, 4'b0000);
    add_n(6, 1'b0, 4'b0000, 4'b0000);
    // All channels change together.
    add_n(5, 1'b0, 4'b1111, 4'b0000);
    add(1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1);
    add_n(1, 1'b0, 4'b1111, 4'b1111);
    add_n(5, 1'b0, 4'b0000, 4'b1111);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    add_n(1, 1'b0, 4'b0000, 4'b0000);
    // ch3 counter reaches 2 after 4 edges, then reset restarts full latency.
    add_n(4, 1'b0, 4'b1000, 4'b0000);
    add_n(1, 1'b1, 4'b1000, 4'b0000);
    add_n(5, 1'b0, 4'b1000, 4'b0000);
    add(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1);
    add_n(2, 1'b0, 4'b1000, 4'b1000);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst;
      sig_a = tbl[i].sig;
      @(posedge clk_ir);
      #1;
      check_all("a", i, so_a, ro_a, fo_a, any_a,
                tbl[i].exp_sig, tbl[i].exp_rise, tbl[i].exp_fall, tbl[i].exp_any);
    end

    // Non-zero reset value: outputs hold 0101 during reset even with 1010 on the input.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_ir);
      #1;
      check_all("b_rst", i, so_b, ro_b, fo_b, any_b, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    end
    rst_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_ir);
      #1;
      if (i < 5)
        check_all("b_rel", i, so_b, ro_b, fo_b, any_b, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      else if (i == 5)
        check_all("b_rel", i, so_b, ro_b, fo_b, any_b, 4'b1010, 4'b1010, 4'b0101, 1'b1);
      else
        check_all("b_rel", i, so_b, ro_b, fo_b, any_b, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    end

    // Pass-through: ch2 toggles every 4 cycles, output follows on the 4th edge (index 3).
    @(posedge clk_ir);
    #1;
    check_all("c_rst", 0, so_c, ro_c, fo_c, any_c, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_c = 1'b0;
    for (int t = 0; t < 4; t++) begin
      logic [3:0] old_v;
      logic [3:0] new_v;
      old_v = sig_c;
      new_v = sig_c ^ 4'b0100;
      sig_c = new_v;
      for (int j = 0; j < 4; j++) begin
        @(posedge clk_ir);
        #1;
        if (j < 3)
          check_all("c_tog", t * 4 + j, so_c, ro_c, fo_c, any_c,
                    old_v, 4'b0000, 4'b0000, 1'b0);
        else
          check_all("c_tog", t * 4 + j, so_c, ro_c, fo_c, any_c, new_v,
                    new_v[2] ? 4'b0100 : 4'b0000, new_v[2] ? 4'b0000 : 4'b0100, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dd_sync_filt.md
# dd_sync_filt

Parametrised multi-channel synchroniser with per-channel glitch filter and edge detection. It is the successor to the basic 2-flop synchroniser. Each of P_WIDTH asynchronous inputs passes through a P_NO_SYNC_STAGES flop chain, then a stability filter that requires P_FILTER_LEN consecutive agreeing samples before the output changes. The block emits one-cycle rise/fall pulses on each accepted change. It sits at the audio_cortex boundary for external buttons, codec status pins and other slow asynchronous levels.

## Interface
- P_WIDTH, 4: number of independent channels
- P_NO_SYNC_STAGES, 2: synchroniser depth; legal range is 2 or more
- P_FILTER_LEN, 4: consecutive synchronised samples required to accept a change; legal range is 1 or more
- P_RST_VAL, 0 (P_WIDTH bits): reset level per channel for the sync chain and for signal_od
- clk_ir  input  1  sole clock
- rst_ih  input  1  synchronous, active-high reset
- signal_id  input  P_WIDTH  asynchronous input levels
- signal_od  output  P_WIDTH  filtered synchronised levels
- rise_od  output  P_WIDTH  one-cycle pulse per channel on an accepted 0->1 change
- fall_od  output  P_WIDTH  one-cycle pulse per channel on an accepted 1->0 change
- any_edge_od  output  1  registered OR-reduction of (rise|fall) from the same cycle's update

## Operation
- Sync stage, per channel c: shift chain sync_f[c]. Its last stage is the synchronised bit s[c].
- Filter state, per channel: the level stable_f (drives signal_od) and the counter cnt_f, width max(1, clog2(P_FILTER_LEN)).
- Each clock with rst_ih low:
  - If s == stable_f: cnt_f <= 0. No pulse.
  - Else if cnt_f == P_FILTER_LEN-1: stable_f <= s, cnt_f <= 0, and the matching rise or fall pulse is set for one cycle.
  - Else: cnt_f <= cnt_f + 1.
- Glitch rejection: the counter clears whenever s returns to stable_f. A disagreement must therefore last P_FILTER_LEN consecutive cycles to be accepted.
- With P_FILTER_LEN = 1 the filter is a single register stage and no cycles are rejected.
- The counter never exceeds P_FILTER_LEN-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous changes on several channels produce pulses in the same cycle, and any_edge_od reports them as a single assertion.
- rise_od and fall_od are never both high on the same channel.

## Timing
- Reset, synchronous, rst_ih high at a clock edge:
  - sync_f[c] <= {P_NO_SYNC_STAGES{P_RST_VAL[c]}}
  - stable_f <= P_RST_VAL
  - cnt_f <= 0
  - rise_od, fall_od, any_edge_od <= 0
- Reset asserted mid-count discards the count and any in-flight sync data.
- No pulse is generated at reset release. An input that differs from P_RST_VAL is accepted through normal latency, with a pulse.
- Latency: an input stable before edge 0 appears on signal_od after edge P_NO_SYNC_STAGES + P_FILTER_LEN - 1, counting edges from 0.
- rise_od and fall_od assert in the same cycle signal_od changes, and are high for exactly one cycle.
- any_edge_od is registered from the same update, so it is coincident with the per-channel pulses.
- All outputs are registered. There are no combinational paths from signal_id.

## Structure
- Shared package audio_cortex_pkg holds:
  - the clog2 function used for the counter width
  - the parameter-legality check: elaboration error when P_NO_SYNC_STAGES < 2 or P_FILTER_LEN < 1
- Sub-module dd_sync_filt_ch implements a single channel: sync chain, filter, and rise/fall registers.
- The top level instantiates P_WIDTH copies in a generate loop and registers the any_edge OR-reduction.

## Test plan
- Reset/idle: P_RST_VAL=4'b0101, hold rst_ih for 3 cycles with signal_id=4'b1010. Required: outputs are 0101/0000/0000/0 during reset. After release, signal_od becomes 1010 exactly 5 edges later (defaults 2+4-1), with rise_od=1000|0010 and fall_od=0101 pulsing once.
- Latency: defaults, ch0 steps 0->1. Required: signal_od[0] rises on edge 5 with a single-cycle rise_od[0]. Then ch0 steps 1->0, and fall_od[0] pulses 5 edges later.
- Glitch rejection: P_FILTER_LEN=4, pulse ch1 high for 3 cycles, low for 1, high for 3. Required: no change on signal_od[1] and no pulses.
- Pass-through: P_FILTER_LEN=1, P_NO_SYNC_STAGES=3, toggle ch2 every 4 cycles. Required: signal_od[2] follows with 3-edge latency and emits one pulse per toggle.
- Simultaneous events: all 4 channels go 0->1 in the same cycle. Required: rise_od=1111 for one cycle and any_edge_od high for that single cycle.
- Reset mid-operation: assert rst_ih while ch3's counter is at 2. Required: after release, the full P_NO_SYNC_STAGES+P_FILTER_LEN-1 latency restarts, with no early pulse.
